// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that shares one registered FP adder among NUM_REQ requesters.
// The operand pair of the granted requester is registered onto the adder inputs. A
// tag pipeline of depth ADDER_LATENCY+1 follows each operation through the adder, so
// that every returned sum carries the ID of the requester that owns it.
// Optional feature: define FP_ADDER_ARBITER_STATS_EN to add saturating per-requester
// grant counters (grant_cnt) with a synchronous clear (stats_clr).

module fp_adder_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ID_W          = 2,
    parameter int unsigned ADDER_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_op_a,
    input  logic [NUM_REQ*32-1:0]   req_op_b,
    output logic [31:0]             adder_in1,
    output logic [31:0]             adder_in2,
    input  logic [31:0]             adder_out,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
`ifdef FP_ADDER_ARBITER_STATS_EN
    input  logic                    stats_clr,
    output logic [NUM_REQ*16-1:0]   grant_cnt,
`endif
    output logic                    busy
);

    localparam logic [ID_W:0]   NumReqW = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]                  ptr_q;
    logic [2*NUM_REQ-1:0]             rot_valid;
    logic [ID_W-1:0]                  offset;
    logic [ID_W:0]                    win_sum;
    logic [ID_W-1:0]                  win;
    logic                             found;
    logic                             xfer;
    logic [31:0]                      sel_a;
    logic [31:0]                      sel_b;
    logic [ID_W-1:0]                  id_in;
    logic [ADDER_LATENCY:0]           tag_vld_q;
    logic [ADDER_LATENCY:0][ID_W-1:0] tag_id_q;

    // Rotate req_valid so that ptr sits at bit 0, take the lowest set bit, and map it back
    always_comb begin
        rot_valid = {req_valid, req_valid} >> ptr_q;
        offset    = '0;
        found     = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                offset = ID_W'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (win_sum >= NumReqW) begin
            win_sum = win_sum - NumReqW;
        end
        win = win_sum[ID_W-1:0];
    end

    // Grant decode and operand mux for the winning requester
    always_comb begin
        xfer      = found && !hold && !reset;
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                req_ready[i] = xfer;
                sel_a        = req_op_a[i*32 +: 32];
                sel_b        = req_op_b[i*32 +: 32];
            end
        end
        // IDs of empty tag slots are zeroed so rsp_id stays quiet between responses
        id_in = xfer ? win : '0;
    end

    // Operand registers, round-robin pointer and the non-stalling tag pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            adder_in1 <= '0;
            adder_in2 <= '0;
            ptr_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            if (xfer) begin
                adder_in1 <= sel_a;
                adder_in2 <= sel_b;
                ptr_q     <= (win == LastIdx) ? '0 : win + ID_W'(1);
            end
            tag_vld_q <= {tag_vld_q[ADDER_LATENCY-1:0], xfer};
            tag_id_q  <= {tag_id_q[ADDER_LATENCY-1:0], id_in};
        end
    end

    assign rsp_valid = tag_vld_q[ADDER_LATENCY];
    assign rsp_id    = tag_id_q[ADDER_LATENCY];
    assign rsp_data  = adder_out;
    assign busy      = |tag_vld_q;

`ifdef FP_ADDER_ARBITER_STATS_EN
    logic [NUM_REQ-1:0] xfer_vec;
    assign xfer_vec = req_valid & req_ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] cnt_q;

        // Saturating grant counter; clear has priority over a same-cycle grant
        always_ff @(posedge clk) begin
            if (reset || stats_clr) begin
                cnt_q <= '0;
            end else if (xfer_vec[g] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign grant_cnt[g*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter (NUM_REQ=4, ADDER_LATENCY=1) with a registered reference
// adder. Operands are always equal pairs so the reference adder can produce an exact
// sum by bumping the exponent. A queue model tracks grants and due response cycles.
// When FP_ADDER_ARBITER_STATS_EN is defined the grant counters are exercised too.

module tb_fp_adder_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            reset;
    logic            hold;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_op_a;
    logic [NR*32-1:0] req_op_b;
    logic [31:0]     adder_in1;
    logic [31:0]     adder_in2;
    logic [31:0]     adder_out;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            busy;
`ifdef FP_ADDER_ARBITER_STATS_EN
    logic            stats_clr;
    logic [NR*16-1:0] grant_cnt;
`endif

    fp_adder_arbiter #(
        .NUM_REQ       (NR),
        .ID_W          (2),
        .ADDER_LATENCY (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op_a  (req_op_a),
        .req_op_b  (req_op_b),
        .adder_in1 (adder_in1),
        .adder_in2 (adder_in2),
        .adder_out (adder_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
`ifdef FP_ADDER_ARBITER_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x + x in the sign[0] / exponent[8:1] / mantissa[31:9] layout: exponent plus one
    function automatic logic [31:0] fp_double(input logic [31:0] x);
        return {x[31:9], x[8:1] + 8'd1, x[0]};
    endfunction

    // Registered reference adder, exact only for equal operand pairs
    always @(posedge clk) begin
        adder_out <= (adder_in1 == adder_in2) ? fp_double(adder_in1) : 32'hDEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          id;
        logic [31:0] data;
        int          acc;
        int          due;
    } op_t;

    op_t         q[$];
    int          m_ptr = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          cyc = 0;
    bit          chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_v;
            bit          e_busy;
            int          e_id;
            logic [31:0] e_d;
            int          w;
            logic [3:0]  e_rdy;
            op_t         keep[$];
            e_v = 0; e_busy = 0; e_id = 0; e_d = '0;
            foreach (q[j]) begin
                if (q[j].due == cyc) begin
                    e_v = 1; e_id = q[j].id; e_d = q[j].data;
                end
                if (q[j].acc < cyc && cyc <= q[j].due) e_busy = 1;
            end
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_v});
            check("busy", {31'b0, busy}, {31'b0, e_busy});
            check("adder_in1", adder_in1, m_a);
            check("adder_in2", adder_in2, m_b);
            if (e_v) begin
                check("rsp_id", {30'b0, rsp_id}, 32'(e_id));
                check("rsp_data", rsp_data, e_d);
            end
            foreach (q[j]) if (q[j].due > cyc) keep.push_back(q[j]);
            q = keep;
            w = -1;
            if (!reset && !hold) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            e_rdy = '0;
            if (w >= 0) e_rdy[w] = 1'b1;
            check("req_ready", {28'b0, req_ready}, {28'b0, e_rdy});
            if (reset) begin
                q.delete();
                m_ptr = 0; m_a = '0; m_b = '0;
            end else if (w >= 0) begin
                op_t t;
                t.id = w; t.data = fp_double(req_op_a[w*32 +: 32]); t.acc = cyc; t.due = cyc + 2;
                q.push_back(t);
                m_a = req_op_a[w*32 +: 32];
                m_b = req_op_b[w*32 +: 32];
                m_ptr = (w + 1) % NR;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_op_a[i*32 +: 32] = v;
        req_op_b[i*32 +: 32] = v;
    endtask

    function automatic logic [31:0] val(input int i);
        return {23'(i * 3 + 1), 8'(100 + i * 5), 1'b0};
    endfunction

    task automatic drain(input int n);
        req_valid = '0;
        hold = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Present a valid pattern for one cycle and pin the expected grant vector
    task automatic grant_cycle(input string name, input logic [3:0] vld, input logic [3:0] exp);
        req_valid = vld;
        @(negedge clk);
        check(name, {28'b0, req_ready}, {28'b0, exp});
        step();
    endtask

    initial begin
        reset = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        req_op_a = '0;
        req_op_b = '0;
`ifdef FP_ADDER_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        step();
        step();
        chk_en = 1;
        // reset state, with all requesters valid to show ready stays low
        req_valid = 4'hF;
        @(negedge clk);
        check("reset_ready", {28'b0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_id", {30'b0, rsp_id}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_adder_in1", adder_in1, 32'h0);
        step();
        reset = 1'b0;
        req_valid = '0;
        step();

        // single op: req 2 adds 1.0 + 1.0
        set_op(2, 32'h0000_00FE);
        grant_cycle("single_ready", 4'b0100, 4'b0100);
        req_valid = '0;
        @(negedge clk);
        check("single_busy_c1", {31'b0, busy}, 32'h1);
        check("single_rsp_early", {31'b0, rsp_valid}, 32'h0);
        step();
        @(negedge clk);
        check("single_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("single_rsp_id", {30'b0, rsp_id}, 32'h2);
        check("single_rsp_data", rsp_data, 32'h0000_0100);
        check("single_busy_c2", {31'b0, busy}, 32'h1);
        step();
        @(negedge clk);
        check("single_busy_c3", {31'b0, busy}, 32'h0);
        step();

        // round-robin from reset, all four continuously valid
        for (int i = 0; i < NR; i++) set_op(i, val(i));
        do_reset();
        grant_cycle("rr_0", 4'hF, 4'b0001);
        grant_cycle("rr_1", 4'hF, 4'b0010);
        grant_cycle("rr_2", 4'hF, 4'b0100);
        grant_cycle("rr_3", 4'hF, 4'b1000);
        grant_cycle("rr_4", 4'hF, 4'b0001);
        grant_cycle("rr_5", 4'hF, 4'b0010);
        drain(3);

        // hold: three grants, then three held cycles, then resume after last winner
        grant_cycle("hold_g0", 4'hF, 4'b0100);
        grant_cycle("hold_g1", 4'hF, 4'b1000);
        grant_cycle("hold_g2", 4'hF, 4'b0001);
        hold = 1'b1;
        grant_cycle("hold_h0", 4'hF, 4'b0000);
        grant_cycle("hold_h1", 4'hF, 4'b0000);
        grant_cycle("hold_h2", 4'hF, 4'b0000);
        hold = 1'b0;
        grant_cycle("hold_resume", 4'hF, 4'b0010);
        drain(3);

        // single requester back-to-back
        grant_cycle("solo_0", 4'b1000, 4'b1000);
        grant_cycle("solo_1", 4'b1000, 4'b1000);
        grant_cycle("solo_2", 4'b1000, 4'b1000);
        drain(3);

        // sparse valids with pointer wrap past index 3
        do_reset();
        grant_cycle("sparse_0", 4'b1010, 4'b0010);
        grant_cycle("sparse_1", 4'b1010, 4'b1000);
        grant_cycle("sparse_2", 4'b1010, 4'b0010);
        grant_cycle("sparse_3", 4'b1010, 4'b1000);
        drain(3);

        // reset mid-flight: accept from req 2, then reset; result must be dropped
        grant_cycle("rmf_accept", 4'b0100, 4'b0100);
        reset = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        check("rmf_ready_in_reset", {28'b0, req_ready}, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rmf_rsp_dropped", {31'b0, rsp_valid}, 32'h0);
        check("rmf_busy_cleared", {31'b0, busy}, 32'h0);
        check("rmf_adder_in1", adder_in1, 32'h0);
        check("rmf_first_grant", {28'b0, req_ready}, 32'b0010);
        step();
        drain(3);

`ifdef FP_ADDER_ARBITER_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) grant_cycle("stats_grant", 4'b0001, 4'b0001);
        req_valid = '0;
        @(negedge clk);
        check("stats_cnt5", {16'b0, grant_cnt[15:0]}, 32'd5);
        check("stats_cnt_other", {16'b0, grant_cnt[31:16]}, 32'd0);
        stats_clr = 1'b1;
        grant_cycle("stats_clr_grant", 4'b0001, 4'b0001);
        stats_clr = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("stats_cleared", {16'b0, grant_cnt[15:0]}, 32'd0);
        step();
        drain(3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered single-precision FP adder among NUM_REQ requesters.
- Accepts operand pairs through per-requester valid/ready handshakes.
- Registers the granted pair onto the adder inputs.
- Tracks the requester ID through a tag pipeline matched to the adder latency.
- Returns each sum tagged with its requester ID.
- Sits between the vector/accumulation front-ends and the adder wrapper instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester ID; must be >= clog2(NUM_REQ)
ADDER_LATENCY, 1, register stages inside the attached adder, from adder inputs to adder_out (1..4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active-high
hold  input  1  when high, no new grants are issued; in-flight operations still complete
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_op_a  input  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_op_b  input  NUM_REQ*32  operand B, same packing
adder_in1  output  32  registered operand A to shared adder
adder_in2  output  32  registered operand B to shared adder
adder_out  input  32  adder result, valid ADDER_LATENCY cycles after adder_in1/adder_in2 update
rsp_valid  output  1  one-cycle pulse, result present
rsp_id  output  ID_W  requester that owns rsp_data
rsp_data  output  32  sum (adder_out passed through)
busy  output  1  any operation in flight in the tag pipeline

Behaviour:
- Word format passes through untouched: sign bit 0, exponent [8:1], mantissa [31:9]. The block performs no arithmetic on operands.
- Arbitration is combinational each cycle:
  - Search req_valid starting at ptr, wrapping modulo NUM_REQ; first set bit wins.
  - req_ready[win] = 1 only if hold = 0 and reset = 0; all other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] & req_ready[i]. At most one transfer per cycle, i.e. one issue per cycle sustained.
- On transfer:
  - adder_in1 <= op_a[win] and adder_in2 <= op_b[win].
  - Tag stage 0 <= {1, win}.
  - ptr <= (win+1) mod NUM_REQ.
- No transfer:
  - adder_in1/adder_in2 hold their previous values to avoid toggling.
  - Tag stage 0 valid <= 0.
  - ptr unchanged.
- Tag pipeline has ADDER_LATENCY stages after stage 0 and shifts every cycle; the tag never stalls.
  - Final stage drives rsp_valid/rsp_id.
  - rsp_data = adder_out, combinational.
- Latency: accept at edge N → rsp_valid high during cycle N+ADDER_LATENCY+1, i.e. ADDER_LATENCY+1 cycles.
- There is no response backpressure; consumers must sink rsp_valid every cycle.
- busy = OR of all tag-stage valid bits.
- Fairness: a continuously-valid requester is granted within NUM_REQ cycles while hold = 0.
- hold asserted mid-stream: in-flight ops still produce responses; no new grants.
- Single requester valid: granted every cycle, back-to-back.
- ptr wrap: grant to NUM_REQ-1 sets ptr to 0.
- Reset:
  - adder_in1/adder_in2 = 0, ptr = 0, all tag valids = 0.
  - rsp_valid = 0, rsp_id = 0, busy = 0, req_ready = 0.
  - Reset mid-operation discards in-flight results; no rsp_valid for them after reset deasserts.

Optional Feature:
FP_ADDER_ARBITER_STATS_EN
- Defined: adds output grant_cnt, width NUM_REQ*16, with a 16-bit per-requester counter.
  - Counter increments on each transfer of that requester and saturates at 0xFFFF.
  - Counters clear on reset.
  - Adds input stats_clr (1 bit), a synchronous clear; clear wins over a simultaneous increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
All scenarios use ADDER_LATENCY=1 with a registered reference adder model on adder_in1/adder_in2→adder_out. Values: 1.0 = 0x000000FE, 2.0 = 0x00000100.
- Single op: req 2 presents 1.0+1.0 at cycle 0 → req_ready[2]=1 in cycle 0; rsp_valid=1, rsp_id=2, rsp_data=0x00000100 in cycle 2; busy high during cycles 1-2.
- Round-robin: all 4 valid continuously from reset → grant order 0,1,2,3,0,1; responses in the same order, one per cycle, from cycle 2.
- Hold: 3 ops accepted back-to-back, hold=1 on the 4th cycle for 3 cycles → 3 responses still emerge; no req_ready during hold; next grant is the requester after the last winner.
- Ptr wrap with sparse valids: only req 1 and req 3 valid → alternation 1,3,1,3; ptr resets correctly past index 3.
- Reset mid-flight: accept op, assert reset the next cycle for 1 cycle → no rsp_valid afterwards; all outputs at reset values; first post-reset grant goes to lowest valid index.
- Stats (macro defined): req 0 granted 5 times then stats_clr pulsed together with a grant → grant_cnt[15:0] = 0 the cycle after.
